// File: rtl/output_conditioner_if.sv
// output_conditioner_if
// Groups the request/level/pulse signals that pass between a requester
// and the output conditioner.
//   rise_req, fall_req : single-cycle edge requests (requester -> conditioner)
//   pinout             : conditioned, registered output level
//   rising, falling    : one-cycle pulses marking a change of pinout
//   busy               : a dwell is in progress or a request is pending
//   dropped            : one-cycle pulse, a request was discarded
// The master modport is the requester side; the slave modport is the
// conditioner side.
interface output_conditioner_if;
   logic rise_req;
   logic fall_req;
   logic pinout;
   logic rising;
   logic falling;
   logic busy;
   logic dropped;

   modport master (
      output rise_req,
      output fall_req,
      input  pinout,
      input  rising,
      input  falling,
      input  busy,
      input  dropped
   );

   modport slave (
      input  rise_req,
      input  fall_req,
      output pinout,
      output rising,
      output falling,
      output busy,
      output dropped
   );
endinterface

// File: rtl/output_conditioner.sv
// output_conditioner
// Transmit-side counterpart of the input conditioner. Takes single-cycle
// rise/fall requests and drives one glitch-free registered output that
// holds each level for at least waittime+1 clock cycles. A request that
// arrives while a level is still dwelling is parked in a one-deep pending
// slot; a request that is overwritten, or a simultaneous rise+fall, is
// reported on dropped.
// Ports:
//   clk     : system clock, all logic on the rising edge
//   reset_n : asynchronous active-low reset, clears every register
//   bus     : output_conditioner_if.slave (requests in, level/pulses out)
// Parameters:
//   counterwidth : width of the dwell counter
//   waittime     : dwell cycles loaded on each transition (1..2^counterwidth-1)
module output_conditioner #(
   parameter int counterwidth = 3,
   parameter int waittime     = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output_conditioner_if.slave   bus
);

   localparam logic [counterwidth-1:0] loadval = counterwidth'(waittime);

   logic                    pinout_q;
   logic [counterwidth-1:0] count;
   logic                    pend_valid;
   logic                    pend_level;
   logic                    rising_q;
   logic                    falling_q;
   logic                    dropped_q;

   logic                    pinout_n;
   logic [counterwidth-1:0] count_n;
   logic                    pend_valid_n;
   logic                    pend_level_n;
   logic                    rising_n;
   logic                    falling_n;
   logic                    dropped_n;

   logic                    req_valid;
   logic                    req_level;
   logic                    conflict;
   logic                    target_valid;
   logic                    target;

   // Request decode. Exactly one of rise/fall makes a valid request; both
   // at once is contradictory, so it is ignored and only reported.
   always_comb begin
      conflict  = bus.rise_req & bus.fall_req;
      req_valid = bus.rise_req ^ bus.fall_req;
      req_level = bus.rise_req;
   end

   // Next-state logic. With the counter at zero the output is free to move:
   // a fresh request beats the pending one (which is then reported as
   // dropped), otherwise the pending level is applied. A target equal to
   // the current level is a silent no-op. While the counter runs the output
   // is frozen and any request goes into the pending slot, newest wins.
   always_comb begin
      pinout_n     = pinout_q;
      count_n      = count;
      pend_valid_n = pend_valid;
      pend_level_n = pend_level;
      rising_n     = 1'b0;
      falling_n    = 1'b0;
      dropped_n    = conflict;
      target_valid = 1'b0;
      target       = pinout_q;

      if (count == '0) begin
         if (req_valid) begin
            target_valid = 1'b1;
            target       = req_level;
            if (pend_valid) begin
               dropped_n = 1'b1;
            end
         end else if (pend_valid) begin
            target_valid = 1'b1;
            target       = pend_level;
         end
         pend_valid_n = 1'b0;
         if (target_valid && (target != pinout_q)) begin
            pinout_n  = target;
            count_n   = loadval;
            rising_n  = target;
            falling_n = ~target;
         end
      end else begin
         count_n = count - 1'b1;
         if (req_valid) begin
            pend_level_n = req_level;
            pend_valid_n = 1'b1;
            if (pend_valid) begin
               dropped_n = 1'b1;
            end
         end
      end
   end

   // State register. Reset clears everything at once, including a dwell in
   // progress and any pending request, without producing any pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pinout_q   <= 1'b0;
         count      <= '0;
         pend_valid <= 1'b0;
         pend_level <= 1'b0;
         rising_q   <= 1'b0;
         falling_q  <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         pinout_q   <= pinout_n;
         count      <= count_n;
         pend_valid <= pend_valid_n;
         pend_level <= pend_level_n;
         rising_q   <= rising_n;
         falling_q  <= falling_n;
         dropped_q  <= dropped_n;
      end
   end

   // Every output except busy comes straight from a flop; busy is a pure
   // function of flops so it cannot glitch on request inputs either.
   assign bus.pinout  = pinout_q;
   assign bus.rising  = rising_q;
   assign bus.falling = falling_q;
   assign bus.dropped = dropped_q;
   assign bus.busy    = (count != '0) | pend_valid;

endmodule

// File: tb/tb_output_conditioner.sv
// tb_output_conditioner
// Directed bench for output_conditioner with waittime=3 and a 20 ns clock.
// Each cycle the observed vector {pinout, rising, falling, busy, dropped}
// is compared with a hand-computed value, 1 ns after the rising edge.
module tb_output_conditioner;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   output_conditioner_if ifc ();

   output_conditioner #(
      .counterwidth (3),
      .waittime     (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Drive the requests for the coming edge, then advance to 1 ns past it.
   task automatic applyStimulus(input logic rise, input logic fall);
      ifc.rise_req = rise;
      ifc.fall_req = fall;
      @(posedge clk);
      #1;
      ifc.rise_req = 1'b0;
      ifc.fall_req = 1'b0;
   endtask

   // Reset held across one edge and released 1 ns after it.
   task automatic apply_reset();
      ifc.rise_req = 1'b0;
      ifc.fall_req = 1'b0;
      reset_n      = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Vector order: pinout, rising, falling, busy, dropped.
   task automatic test_reset();
      logic [4:0] obs;
      apply_reset();
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_state: got %b expected %b", obs, 5'b00000);
      end
   endtask

   task automatic test_idle();
      logic [4:0] obs;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0);
         obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
         checks++;
         if (obs !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL idle_cycle%0d: got %b expected %b", i, obs, 5'b00000);
         end
      end
   endtask

   // Rise sampled at the end of cycle 2; checks cycles 3..6.
   task automatic test_single_rise();
      logic [4:0] obs;
      logic [4:0] exp [4] = '{5'b11010, 5'b10010, 5'b10010, 5'b10000};
      apply_reset();
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("[TB] FAIL single_rise_c%0d: got %b expected %b", i + 3, obs, exp[i]);
         end
         applyStimulus(1'b0, 1'b0);
      end
   endtask

   // Fall arrives mid-dwell, is pended and applied in cycle 7.
   task automatic test_pend();
      logic [4:0] obs;
      logic [4:0] exp [5] = '{5'b11010, 5'b10010, 5'b10010, 5'b10010, 5'b00110};
      apply_reset();
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("[TB] FAIL pend_c%0d: got %b expected %b", i + 3, obs, exp[i]);
         end
         applyStimulus(1'b0, (i == 0));
      end
   endtask

   // Fall then rise during the dwell: the rise overwrites the fall, which
   // is reported; the surviving pending level equals pinout so no change.
   task automatic test_supersede();
      logic [4:0] obs;
      logic [4:0] exp [3] = '{5'b10011, 5'b10010, 5'b10000};
      apply_reset();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("[TB] FAIL supersede_c%0d: got %b expected %b", i + 5, obs, exp[i]);
         end
         applyStimulus(1'b0, 1'b0);
      end
   endtask

   task automatic test_conflict();
      logic [4:0] obs;
      apply_reset();
      applyStimulus(1'b1, 1'b1);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL conflict_drop: got %b expected %b", obs, 5'b00001);
      end
      applyStimulus(1'b0, 1'b0);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL conflict_after: got %b expected %b", obs, 5'b00000);
      end
   endtask

   task automatic test_redundant();
      logic [4:0] obs;
      apply_reset();
      applyStimulus(1'b0, 1'b1);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL redundant_fall: got %b expected %b", obs, 5'b00000);
      end
   endtask

   // A fall driven in cycle 6 (counter already zero) takes effect at once,
   // so the high level lasts exactly waittime+1 = 4 cycles.
   task automatic test_min_dwell();
      logic [4:0] obs;
      apply_reset();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL min_dwell_c6: got %b expected %b", obs, 5'b10000);
      end
      applyStimulus(1'b0, 1'b1);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00110) begin
         errors++;
         $display("[TB] FAIL min_dwell_c7: got %b expected %b", obs, 5'b00110);
      end
   endtask

   // Reset asserted between edges with pinout=1, count=2, pending fall.
   task automatic test_reset_middwell();
      logic [4:0] obs;
      apply_reset();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b10010) begin
         errors++;
         $display("[TB] FAIL middwell_setup: got %b expected %b", obs, 5'b10010);
      end
      #3;
      reset_n = 1'b0;
      #1;
      obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL middwell_async: got %b expected %b", obs, 5'b00000);
      end
      #4;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         obs = {ifc.pinout, ifc.rising, ifc.falling, ifc.busy, ifc.dropped};
         checks++;
         if (obs !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL middwell_after%0d: got %b expected %b", i, obs, 5'b00000);
         end
         applyStimulus(1'b0, 1'b0);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset_n      = 1'b0;
      ifc.rise_req = 1'b0;
      ifc.fall_req = 1'b0;
      #5;
      test_reset();
      test_idle();
      test_single_rise();
      test_pend();
      test_supersede();
      test_conflict();
      test_redundant();
      test_min_dwell();
      test_reset_middwell();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
